// File: rtl/tcdm_stream_reader.sv
// Strided TCDM read initiator: turns one (addr, len, stride) command into word reads
// and returns the data in order on a valid/ready stream, issuing only against free FIFO credit.
module tcdm_stream_reader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [31:0]      cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [31:0]      cmd_stride_i,
    output logic             tcdm_req_o,
    input  logic             tcdm_gnt_i,
    output logic [31:0]      tcdm_add_o,
    output logic             tcdm_wen_o,
    output logic [3:0]       tcdm_be_o,
    output logic [31:0]      tcdm_data_o,
    input  logic [31:0]      tcdm_r_data_i,
    input  logic             tcdm_r_valid_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_addr, r_stride;
    logic [LEN_W-1:0] r_issue_cnt, r_pop_cnt;
    logic             r_inflight, r_done;
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_acc, w_gnt, w_push, w_pop, w_credit;

    assign w_acc    = cmd_valid_i && (r_state == IDLE);
    assign w_gnt    = tcdm_req_o && tcdm_gnt_i;
    assign w_push   = tcdm_r_valid_i && r_inflight;
    assign w_pop    = out_valid_o && out_ready_i;
    // A granted word still in flight already owns a FIFO slot; pops only free credit next cycle.
    assign w_credit = (r_count + CW'(r_inflight)) < DEPTH_C;

    assign tcdm_add_o  = r_addr;
    assign tcdm_wen_o  = 1'b1;
    assign tcdm_be_o   = 4'hF;
    assign tcdm_data_o = 32'h0;
    assign out_valid_o = (r_count != '0);
    assign out_data_o  = r_mem[r_rptr];
    assign done_o      = r_done;

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b0;
        tcdm_req_o  = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (w_acc && (cmd_len_i != '0))
                    w_state_nxt = ISSUE;
            end
            ISSUE: begin
                busy_o     = 1'b1;
                tcdm_req_o = w_credit;
                if (w_gnt && (r_issue_cnt == LEN_W'(1)))
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (r_pop_cnt == '0)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_stride    <= '0;
            r_issue_cnt <= '0;
            r_pop_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_gnt;
            r_done     <= (w_acc && (cmd_len_i == '0)) ||
                          (w_pop && (r_pop_cnt == LEN_W'(1)));
            if (w_acc) begin
                r_addr      <= cmd_addr_i;
                r_stride    <= cmd_stride_i;
                r_issue_cnt <= cmd_len_i;
                r_pop_cnt   <= cmd_len_i;
            end else begin
                if (w_gnt) begin
                    r_addr      <= r_addr + r_stride;
                    r_issue_cnt <= r_issue_cnt - LEN_W'(1);
                end
                if (w_pop)
                    r_pop_cnt <= r_pop_cnt - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= tcdm_r_data_i;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        tcdm_r_valid_i |-> r_inflight);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_push |-> (r_count < DEPTH_C));

endmodule

// File: tb/tb_tcdm_stream_reader.sv
// Bench for tcdm_stream_reader: a one-cycle-latency memory responder plus address/data
// scoreboards filled when each command is driven and drained as requests/words appear.
module tb_tcdm_stream_reader;
    logic        clk_i, rst_ni;
    logic        cmd_valid_i, cmd_ready_o;
    logic [31:0] cmd_addr_i, cmd_stride_i;
    logic [15:0] cmd_len_i;
    logic        tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
    logic [31:0] tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
    logic [3:0]  tcdm_be_o;
    logic        out_valid_o, out_ready_i, busy_o, done_o;
    logic [31:0] out_data_o;

    tcdm_stream_reader #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_stride_i(cmd_stride_i),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_vec = 0, n_err = 0;
    logic [31:0] exp_add_q[$];
    logic [31:0] exp_dat_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // memory responder + monitor, sampling 1 time unit after the falling edge
    logic        gnt_rand = 1'b0;
    logic        pend_v = 1'b0, p_req = 1'b0, p_gnt = 1'b0, p_ov = 1'b0, p_or = 1'b0, p_done = 1'b0;
    logic [31:0] pend_a = '0, p_add = '0, p_od = '0;
    int cyc = 0, n_gnt = 0, n_done = 0, acc_cyc = 0, g_first = -1, g_last = 0, p_first = -1;

    always @(negedge clk_i) begin
        tcdm_gnt_i = gnt_rand ? ($urandom_range(0, 99) >= 30) : 1'b1;
        #1;
        cyc++;
        if (!rst_ni) begin
            pend_v = 1'b0; p_req = 1'b0; p_ov = 1'b0; p_done = 1'b0;
        end else begin
            if (p_req && !p_gnt) begin
                chk("req_hold", 32'(tcdm_req_o), 1);
                chk("add_hold", tcdm_add_o, p_add);
            end
            if (p_ov && !p_or) chk("data_hold", out_data_o, p_od);
            if (p_done) chk("busy_after_done", 32'(busy_o), 0);
            if (cmd_valid_i && cmd_ready_o) acc_cyc = cyc;
            pend_v = tcdm_req_o && tcdm_gnt_i;
            pend_a = tcdm_add_o;
            if (pend_v) begin
                n_gnt++;
                if (g_first < 0) g_first = cyc;
                g_last = cyc;
                if (exp_add_q.size() == 0) chk("add_unexpected", 32'(exp_add_q.size()), 1);
                else chk("add", tcdm_add_o, exp_add_q.pop_front());
            end
            if (out_valid_o && out_ready_i) begin
                if (p_first < 0) p_first = cyc;
                if (exp_dat_q.size() == 0) chk("data_unexpected", 32'(exp_dat_q.size()), 1);
                else chk("data", out_data_o, exp_dat_q.pop_front());
            end
            if (done_o) n_done++;
            p_req = tcdm_req_o; p_gnt = tcdm_gnt_i; p_add = tcdm_add_o;
            p_ov = out_valid_o; p_or = out_ready_i; p_od = out_data_o; p_done = done_o;
        end
    end

    always @(posedge clk_i) begin
        #1;
        tcdm_r_valid_i = pend_v && rst_ni;
        tcdm_r_data_i  = pend_v ? mem_f(pend_a) : 32'h0;
    end

    task automatic send_cmd(input logic [31:0] a, input int len, input logic [31:0] s);
        int t;
        for (int i = 0; i < len; i++) begin
            exp_add_q.push_back(a + 32'(i) * s);
            exp_dat_q.push_back(mem_f(a + 32'(i) * s));
        end
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_len_i = 16'(len); cmd_stride_i = s;
        t = 0;
        while (!cmd_ready_o && t < 100) begin @(negedge clk_i); t++; end
        if (t >= 100) chk("cmd_accept_timeout", 32'(cmd_ready_o), 1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int lim);
        int t = 0;
        while (n_done == d0 && t < lim) begin @(negedge clk_i); #2; t++; end
        if (t >= lim) chk("done_timeout", 32'(n_done - d0), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(tcdm_req_o), 0);
        chk({tag, "_wen"}, 32'(tcdm_wen_o), 1);
        chk({tag, "_be"}, 32'(tcdm_be_o), 32'hF);
        chk({tag, "_wdata"}, tcdm_data_o, 0);
        chk({tag, "_ovalid"}, 32'(out_valid_o), 0);
        chk({tag, "_odata"}, out_data_o, 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
    endtask

    initial begin
        int d0, g0;
        rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0; cmd_stride_i = '0;
        tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0; out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #2 chk_reset_outputs("rst");
        @(negedge clk_i) rst_ni = 1'b1;

        // contiguous burst: latency and back-to-back issue
        g_first = -1; p_first = -1; d0 = n_done;
        send_cmd(32'h1C01_0000, 8, 32'd4);
        wait_done(d0, 200);
        chk("c_first_req_lat", 32'(g_first - acc_cyc), 1);
        chk("c_burst_span", 32'(g_last - g_first), 7);
        chk("c_out_lat", 32'(p_first - g_first), 2);
        repeat (3) @(negedge clk_i);
        #2 chk("c_done_count", 32'(n_done - d0), 1);
        chk("c_addq_empty", 32'(exp_add_q.size()), 0);
        chk("c_datq_empty", 32'(exp_dat_q.size()), 0);

        // output backpressure: only FIFO_DEPTH grants
        out_ready_i = 1'b0; g0 = n_gnt; d0 = n_done;
        send_cmd(32'h1C02_0000, 16, 32'd4);
        repeat (20) @(negedge clk_i);
        #2;
        chk("bp_grants", 32'(n_gnt - g0), 4);
        chk("bp_req_low", 32'(tcdm_req_o), 0);
        chk("bp_out_valid", 32'(out_valid_o), 1);
        @(negedge clk_i) out_ready_i = 1'b1;
        wait_done(d0, 300);
        chk("bp_datq_empty", 32'(exp_dat_q.size()), 0);

        // random grant stalls with a non-unit stride
        gnt_rand = 1'b1; d0 = n_done;
        send_cmd(32'h1C03_0000, 10, 32'd12);
        wait_done(d0, 500);
        gnt_rand = 1'b0;
        chk("st_datq_empty", 32'(exp_dat_q.size()), 0);

        // zero-length command
        @(negedge clk_i);
        g0 = n_gnt; d0 = n_done;
        send_cmd(32'h1C04_0000, 0, 32'd4);
        @(negedge clk_i); #2;
        chk("l0_done", 32'(done_o), 1);
        chk("l0_cmd_ready", 32'(cmd_ready_o), 1);
        chk("l0_busy", 32'(busy_o), 0);
        @(negedge clk_i); #2;
        chk("l0_done_off", 32'(done_o), 0);
        chk("l0_no_req", 32'(n_gnt - g0), 0);
        chk("l0_cmd_ready2", 32'(cmd_ready_o), 1);

        // 32-bit address wrap
        d0 = n_done;
        send_cmd(32'hFFFF_FFF8, 4, 32'd4);
        wait_done(d0, 200);
        chk("wr_addq_empty", 32'(exp_add_q.size()), 0);

        // reset in the middle of a long command
        send_cmd(32'h1C05_0000, 32, 32'd4);
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b0;
        exp_add_q.delete(); exp_dat_q.delete();
        #2 chk_reset_outputs("mid_rst");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #2 chk("post_rst_empty", 32'(out_valid_o), 0);
        d0 = n_done;
        send_cmd(32'h1C06_0000, 2, 32'd8);
        wait_done(d0, 200);
        chk("post_rst_datq_empty", 32'(exp_dat_q.size()), 0);
        chk("post_rst_addq_empty", 32'(exp_add_q.size()), 0);

        repeat (3) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
